// File: rtl/fpu_reader_pkg.sv
// Shared types and sizing constants for the FPU master RAM burst reader.
package fpu_reader_pkg;

    localparam int ADDR_W = 4;
    localparam int CNT_W  = ADDR_W + 1;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/fpu_reader_skid.sv
// Two-entry output buffer carrying RAM words (plus a LAST tag) to the consumer
// with a valid/ready handshake; the head entry drives the outputs directly.
module fpu_reader_skid
    import fpu_reader_pkg::*;
#(
    parameter int Width = 32
) (
    input  logic             clk_i,
    input  logic             resetN_i,
    input  logic             inValid_i,
    input  logic [Width-1:0] inData_i,
    input  logic             inLast_i,
    input  logic             outReady_i,
    output logic             outValid_o,
    output logic [Width-1:0] outData_o,
    output logic             outLast_o,
    output logic [1:0]       count_o
);

    logic [Width:0] head_q, head_d;
    logic [Width:0] tail_q, tail_d;
    logic [1:0]     count_q, count_d;
    logic [Width:0] inWord;
    logic           pop;

    assign inWord = {inLast_i, inData_i};

    // The reader only pushes when a slot is guaranteed, so a push into a
    // full buffer is always paired with a pop.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        pop     = (count_q != 2'd0) && outReady_i;
        case (count_q)
            2'd0: begin
                if (inValid_i) begin
                    head_d  = inWord;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (inValid_i && pop) begin
                    head_d = inWord;
                end else if (inValid_i) begin
                    tail_d  = inWord;
                    count_d = 2'd2;
                end else if (pop) begin
                    count_d = 2'd0;
                end
            end
            default: begin
                if (pop) begin
                    head_d = tail_q;
                    if (inValid_i) begin
                        tail_d = inWord;
                    end else begin
                        count_d = 2'd1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!resetN_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign outValid_o = (count_q != 2'd0);
    assign outData_o  = head_q[Width-1:0];
    assign outLast_o  = head_q[Width] && outValid_o;
    assign count_o    = count_q;

endmodule

// File: rtl/fpu_master_reader.sv
// Burst reader: streams REQ_CNT consecutive words from the FPU master RAM to a
// valid/ready consumer. Define FPU_READER_REVERSE_EN to add REQ_DIR (descending bursts).
module fpu_master_reader
    import fpu_reader_pkg::*;
#(
    parameter int Width = 32,
    parameter int AddrW = ADDR_W
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             REQ,
    input  logic [AddrW-1:0] REQ_ADDR,
    input  logic [AddrW:0]   REQ_CNT,
`ifdef FPU_READER_REVERSE_EN
    input  logic             REQ_DIR,
`endif
    output logic             BUSY,
    output logic             RDEN,
    output logic [AddrW-1:0] RADDR,
    input  logic [Width-1:0] DI,
    output logic [Width-1:0] DO,
    output logic             DOVALID,
    input  logic             DORDY,
    output logic             LAST,
    output logic             DONE
);

    localparam logic [AddrW-1:0] AddrOne = 1;
    localparam logic [AddrW:0]   CntOne  = 1;

    state_t           state_q, state_d;
    logic [AddrW-1:0] raddr_q, raddr_d;
    logic [AddrW:0]   rdRem_q, rdRem_d;
    logic             diValid_q, diValid_d;
    logic             diLast_q, diLast_d;
`ifdef FPU_READER_REVERSE_EN
    logic             dir_q, dir_d;
`endif

    logic             rden;
    logic             xfer;
    logic             room;
    logic [1:0]       occ;
    logic [2:0]       pending;

    assign xfer = DOVALID && DORDY;

    // A read issued now lands two edges later; allow it only if the buffer
    // could still absorb it even if the consumer stalls from now on.
    assign pending = {1'b0, occ} + {2'b0, diValid_q};
    assign room    = pending < (3'd2 + {2'b0, xfer});

    always_comb begin
        state_d = state_q;
        raddr_d = raddr_q;
        rdRem_d = rdRem_q;
`ifdef FPU_READER_REVERSE_EN
        dir_d   = dir_q;
`endif
        rden    = 1'b0;
        case (state_q)
            IDLE: begin
                if (REQ && (REQ_CNT != '0)) begin
                    state_d = READ;
                    raddr_d = REQ_ADDR;
                    rdRem_d = REQ_CNT;
`ifdef FPU_READER_REVERSE_EN
                    dir_d   = REQ_DIR;
`endif
                end
            end
            READ: begin
                rden = (rdRem_q != '0) && room;
                if (rden) begin
                    rdRem_d = rdRem_q - CntOne;
`ifdef FPU_READER_REVERSE_EN
                    raddr_d = dir_q ? (raddr_q - AddrOne) : (raddr_q + AddrOne);
`else
                    raddr_d = raddr_q + AddrOne;
`endif
                    if (rdRem_q == CntOne) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (xfer && LAST) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        diValid_d = rden;
        diLast_d  = rden && (rdRem_q == CntOne);
    end

    // Clearing diValid_q on reset drops any RAM data still in flight.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q   <= IDLE;
            raddr_q   <= '0;
            rdRem_q   <= '0;
            diValid_q <= 1'b0;
            diLast_q  <= 1'b0;
`ifdef FPU_READER_REVERSE_EN
            dir_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            raddr_q   <= raddr_d;
            rdRem_q   <= rdRem_d;
            diValid_q <= diValid_d;
            diLast_q  <= diLast_d;
`ifdef FPU_READER_REVERSE_EN
            dir_q     <= dir_d;
`endif
        end
    end

    fpu_reader_skid #(
        .Width(Width)
    ) u_skid (
        .clk_i     (CLK),
        .resetN_i  (RESET),
        .inValid_i (diValid_q),
        .inData_i  (DI),
        .inLast_i  (diLast_q),
        .outReady_i(DORDY),
        .outValid_o(DOVALID),
        .outData_o (DO),
        .outLast_o (LAST),
        .count_o   (occ)
    );

    assign BUSY  = (state_q != IDLE);
    assign RDEN  = rden;
    assign RADDR = raddr_q;
    assign DONE  = (state_q == DRAIN) && xfer && LAST;

endmodule
